// File: rtl/alien_fire_scheduler.sv
// Alien rocket launch scheduler: paces launches every FIRE_PERIOD frames, picks a live column,
// looks up its lowest alien and allocates a free rocket slot. Optional macro ALIEN_FIRE_LFSR_EN.
module alien_fire_scheduler #(
  parameter int NUM_SLOTS    = 4,
  parameter int NUM_COLS     = 8,
  parameter int FIRE_PERIOD  = 45,
  parameter int COL_PITCH    = 64,
  parameter int ROW_PITCH    = 32,
  parameter int X_OFFSET     = 28,
  parameter int ROCKET_SPEED = 96,
  localparam int COL_W  = (NUM_COLS  > 1) ? $clog2(NUM_COLS)  : 1,
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     startOfFrame,
  input  logic [NUM_COLS-1:0]      colAlive,
  input  logic signed [10:0]       gridTLX,
  input  logic signed [10:0]       gridTLY,
  input  logic [NUM_SLOTS-1:0]     slotDone,
  output logic [COL_W-1:0]         queryCol,
  input  logic [2:0]               queryBottomRow,
  output logic [NUM_SLOTS-1:0]     isActiveAliens,
  output logic                     launch,
  output logic [SLOT_W-1:0]        launchSlot,
  output logic signed [10:0]       initialX,
  output logic signed [10:0]       initialY,
  output logic signed [8:0]        initialSpeed
);

  localparam int CNT_W = (FIRE_PERIOD > 1) ? $clog2(FIRE_PERIOD) : 1;

  typedef enum logic [1:0] {IDLE, SELECT, QUERY, LAUNCH} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pending_q, pending_d;
  logic [COL_W-1:0]       ptr_q, ptr_d;
  logic [COL_W-1:0]       query_col_q, query_col_d;
  logic [NUM_SLOTS-1:0]   active_q, active_d;
  logic                   launch_q, launch_d;
  logic [SLOT_W-1:0]      launch_slot_q, launch_slot_d;
  logic signed [10:0]     init_x_q, init_x_d;
  logic signed [10:0]     init_y_q, init_y_d;
  logic signed [8:0]      init_speed_q, init_speed_d;

  logic                   fire_due;
  logic                   start_sel;
  logic                   go_launch;
  logic                   free_any;
  logic [SLOT_W-1:0]      free_idx;
  logic [COL_W-1:0]       search_start;
  logic [COL_W-1:0]       pick_col;
  logic [COL_W-1:0]       scan_idx;
  logic signed [10:0]     col_off;
  logic signed [10:0]     row_off;

`ifdef ALIEN_FIRE_LFSR_EN
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= 8'hA5;
    else       lfsr_q <= lfsr_d;
  end

  // The round-robin pointer keeps updating but only the LFSR seeds the search.
  assign search_start = COL_W'(int'(lfsr_q) % NUM_COLS);
`else
  assign search_start = ptr_q;
`endif

  // Lowest-index idle slot.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        free_any = 1'b1;
        free_idx = SLOT_W'(i);
      end
    end
  end

  // First live column at or after search_start, wrapping; scanned backwards so the nearest wins.
  always_comb begin
    pick_col = search_start;
    scan_idx = '0;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      scan_idx = COL_W'((int'(search_start) + i) % NUM_COLS);
      if (colAlive[scan_idx]) pick_col = scan_idx;
    end
  end

  assign fire_due  = startOfFrame && enable && (cnt_q == CNT_W'(FIRE_PERIOD - 1));
  assign start_sel = (state_q == IDLE) && startOfFrame && enable &&
                     (pending_q || fire_due) && free_any && (|colAlive);
  assign go_launch = (state_q == QUERY) && enable && free_any;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_sel) state_d = SELECT;
      SELECT:  state_d = enable ? QUERY : IDLE;
      QUERY:   state_d = go_launch ? LAUNCH : IDLE;
      LAUNCH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Launch coordinates: column captured on entry to SELECT, row returned during QUERY.
  assign col_off = 11'(int'(query_col_q) * COL_PITCH);
  assign row_off = 11'((int'(queryBottomRow) + 1) * ROW_PITCH);

  always_comb begin
    cnt_d         = cnt_q;
    pending_d     = pending_q;
    ptr_d         = ptr_q;
    query_col_d   = query_col_q;
    active_d      = active_q & ~slotDone;
    launch_d      = go_launch;
    launch_slot_d = launch_slot_q;
    init_x_d      = init_x_q;
    init_y_d      = init_y_q;
    init_speed_d  = init_speed_q;

    if (startOfFrame && enable) begin
      cnt_d = fire_due ? '0 : cnt_q + CNT_W'(1);
    end

    if (start_sel) begin
      query_col_d = pick_col;
    end

    if (go_launch) begin
      pending_d               = 1'b0;
      ptr_d                   = (query_col_q == COL_W'(NUM_COLS - 1)) ? '0 : query_col_q + COL_W'(1);
      active_d[free_idx]      = 1'b1;
      launch_slot_d           = free_idx;
      init_x_d                = gridTLX + col_off + 11'(X_OFFSET);
      init_y_d                = gridTLY + row_off;
      init_speed_d            = 9'(ROCKET_SPEED);
    end

    if (fire_due) pending_d = 1'b1;

    if (!enable) begin
      cnt_d     = '0;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      pending_q     <= 1'b0;
      ptr_q         <= '0;
      query_col_q   <= '0;
      active_q      <= '0;
      launch_q      <= 1'b0;
      launch_slot_q <= '0;
      init_x_q      <= '0;
      init_y_q      <= '0;
      init_speed_q  <= '0;
    end else begin
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      ptr_q         <= ptr_d;
      query_col_q   <= query_col_d;
      active_q      <= active_d;
      launch_q      <= launch_d;
      launch_slot_q <= launch_slot_d;
      init_x_q      <= init_x_d;
      init_y_q      <= init_y_d;
      init_speed_q  <= init_speed_d;
    end
  end

  assign queryCol       = query_col_q;
  assign isActiveAliens = active_q;
  assign launch         = launch_q;
  assign launchSlot     = launch_slot_q;
  assign initialX       = init_x_q;
  assign initialY       = init_y_q;
  assign initialSpeed   = init_speed_q;

endmodule

// File: tb/tb_alien_fire_scheduler.sv
// Directed bench for alien_fire_scheduler with FIRE_PERIOD=3 and a one-cycle bottom-row lookup model.
module tb_alien_fire_scheduler;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              startOfFrame;
  logic [7:0]        colAlive;
  logic signed [10:0] gridTLX;
  logic signed [10:0] gridTLY;
  logic [3:0]        slotDone;
  logic [2:0]        queryCol;
  logic [2:0]        queryBottomRow;
  logic [3:0]        isActiveAliens;
  logic              launch;
  logic [1:0]        launchSlot;
  logic signed [10:0] initialX;
  logic signed [10:0] initialY;
  logic signed [8:0] initialSpeed;

  logic [2:0] row_tab [8];

  int n_chk = 0;
  int n_bad = 0;

  alien_fire_scheduler #(.FIRE_PERIOD(3)) dut (
    .clk(clk), .reset(reset), .enable(enable), .startOfFrame(startOfFrame),
    .colAlive(colAlive), .gridTLX(gridTLX), .gridTLY(gridTLY), .slotDone(slotDone),
    .queryCol(queryCol), .queryBottomRow(queryBottomRow), .isActiveAliens(isActiveAliens),
    .launch(launch), .launchSlot(launchSlot), .initialX(initialX), .initialY(initialY),
    .initialSpeed(initialSpeed)
  );

  always #5 clk = ~clk;

  // Alien grid bottom-row lookup: answer arrives one cycle after queryCol.
  always @(posedge clk) queryBottomRow <= row_tab[queryCol];

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic sof_pulse();
    @(negedge clk); startOfFrame = 1'b1;
    @(negedge clk); startOfFrame = 1'b0;
  endtask

  task automatic expect_quiet(input string tag);
    sof_pulse();
    repeat (3) begin
      @(negedge clk);
      check({tag, "_nolaunch"}, int'(launch), 0);
    end
  endtask

  task automatic expect_launch(input string tag, input int col, input int slot,
                               input int x, input int y, input int act);
    sof_pulse();
    @(negedge clk);
    check({tag, "_qcol"}, int'(queryCol), col);
    check({tag, "_early"}, int'(launch), 0);
    @(negedge clk);
    check({tag, "_launch"}, int'(launch), 1);
    check({tag, "_slot"}, int'(launchSlot), slot);
    check({tag, "_x"}, int'(initialX), x);
    check({tag, "_y"}, int'(initialY), y);
    check({tag, "_speed"}, int'(initialSpeed), 96);
    check({tag, "_act"}, int'(isActiveAliens), act);
    @(negedge clk);
    check({tag, "_pulse1"}, int'(launch), 0);
    check({tag, "_xhold"}, int'(initialX), x);
  endtask

  task automatic done_pulse(input logic [3:0] d);
    @(negedge clk); slotDone = d;
    @(negedge clk); slotDone = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_act"}, int'(isActiveAliens), 0);
    check({tag, "_launch"}, int'(launch), 0);
    check({tag, "_slot"}, int'(launchSlot), 0);
    check({tag, "_qcol"}, int'(queryCol), 0);
    check({tag, "_x"}, int'(initialX), 0);
    check({tag, "_y"}, int'(initialY), 0);
    check({tag, "_speed"}, int'(initialSpeed), 0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; startOfFrame = 1'b0; colAlive = '0;
    gridTLX = '0; gridTLY = '0; slotDone = '0;
    for (int i = 0; i < 8; i++) row_tab[i] = 3'd2;
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    reset = 1'b0;

    // Basic launch on the third frame
    enable = 1'b1; colAlive = 8'hFF; gridTLX = 11'sd100; gridTLY = 11'sd40;
    expect_quiet("t1a");
    expect_quiet("t1b");
    expect_launch("t1", 0, 0, 128, 136, 4'b0001);

    // Round-robin over sparse columns from a fresh pointer
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("t2_rst_act", int'(isActiveAliens), 0);
    colAlive = 8'b1010_0100;
    row_tab[2] = 3'd1; row_tab[5] = 3'd4; row_tab[7] = 3'd7; row_tab[4] = 3'd3;
    expect_quiet("t2a"); expect_quiet("t2a");
    expect_launch("t2_c2", 2, 0, 256, 104, 4'b0001);
    expect_quiet("t2b"); expect_quiet("t2b");
    expect_launch("t2_c5", 5, 1, 448, 200, 4'b0011);
    expect_quiet("t2c"); expect_quiet("t2c");
    expect_launch("t2_c7", 7, 2, 576, 296, 4'b0111);
    expect_quiet("t2d"); expect_quiet("t2d");
    expect_launch("t2_c2b", 2, 3, 256, 104, 4'b1111);

    // All slots busy: no launch until one is released, then retry on next frame
    expect_quiet("t3"); expect_quiet("t3"); expect_quiet("t3_full");
    done_pulse(4'b0100);
    check("t3_done_act", int'(isActiveAliens), 4'b1011);
    expect_launch("t3", 5, 2, 448, 200, 4'b1111);

    // No live column at expiry: pending is held; signed wrap of coordinates
    done_pulse(4'b0001);
    colAlive = '0; gridTLX = 11'sd1000; gridTLY = -11'sd20;
    expect_quiet("t4"); expect_quiet("t4_dead");
    colAlive = 8'h10;
    expect_launch("t4", 4, 0, -764, 108, 4'b1111);

    // enable drops during QUERY: sequence aborts, pointer and counter behave
    done_pulse(4'b0010);
    colAlive = 8'b1010_0100;
    expect_quiet("t5a");
    sof_pulse();
    @(negedge clk);
    check("t5_qcol", int'(queryCol), 5);
    enable = 1'b0;
    @(negedge clk);
    check("t5_abort_launch", int'(launch), 0);
    check("t5_abort_act", int'(isActiveAliens), 4'b1101);
    @(negedge clk);
    check("t5_abort_launch2", int'(launch), 0);
    expect_quiet("t5_dis"); expect_quiet("t5_dis");
    enable = 1'b1;
    expect_quiet("t5b"); expect_quiet("t5b");
    expect_launch("t5", 5, 1, -700, 140, 4'b1111);

    // Asynchronous reset in the middle of a launch cycle
    done_pulse(4'b0011);
    expect_quiet("t6"); expect_quiet("t6");
    sof_pulse();
    @(negedge clk);
    @(negedge clk);
    check("t6_launch", int'(launch), 1);
    check("t6_act", int'(isActiveAliens), 4'b1101);
    check("t6_x", int'(initialX), -572);
    #1 reset = 1'b1;
    #1 check_all_zero("t6_rst");
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    check("t6_post_act", int'(isActiveAliens), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
